// File: rtl/td4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : td4_pkg
// Brief    : Shared opcodes, FSM states and decode select types for the
//            parametrised TD4 core.
// Revision : 1.0 - initial release
// ============================================================================
package td4_pkg;

    localparam int OPW = 4;

    typedef enum logic [3:0] {
        OP_ADD_A     = 4'b0000,
        OP_MOV_A_B   = 4'b0001,
        OP_IN_A      = 4'b0010,
        OP_MOV_A_IMM = 4'b0011,
        OP_MOV_B_A   = 4'b0100,
        OP_ADD_B     = 4'b0101,
        OP_IN_B      = 4'b0110,
        OP_MOV_B_IMM = 4'b0111,
        OP_OUT_B     = 4'b1001,
        OP_OUT_IMM   = 4'b1011,
        OP_JNC       = 4'b1110,
        OP_JMP       = 4'b1111
    } opcode_t;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_A    = 2'd1,
        DST_B    = 2'd2,
        DST_OUT  = 2'd3
    } dest_t;

    typedef enum logic [2:0] {
        SRC_IMM = 3'd0,
        SRC_A   = 3'd1,
        SRC_B   = 3'd2,
        SRC_SW  = 3'd3,
        SRC_SUM = 3'd4
    } src_t;

endpackage
`default_nettype wire

// File: rtl/td4_decode.sv
`default_nettype none
// ============================================================================
// Module   : td4_decode
// Brief    : Combinational instruction decoder: destination/source selects,
//            add flag and jump resolution against the carry flag.
// Revision : 1.0 - initial release
// ============================================================================
module td4_decode
    import td4_pkg::*;
(
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_cf,
    output dest_t          o_dest,
    output src_t           o_src,
    output logic           o_is_add,
    output logic           o_jump_taken
);

    always_comb begin
        o_dest       = DST_NONE;
        o_src        = SRC_IMM;
        o_is_add     = 1'b0;
        o_jump_taken = 1'b0;
        case (i_opcode)
            OP_ADD_A:     begin o_dest = DST_A;   o_src = SRC_SUM; o_is_add = 1'b1; end
            OP_MOV_A_B:   begin o_dest = DST_A;   o_src = SRC_B;   end
            OP_IN_A:      begin o_dest = DST_A;   o_src = SRC_SW;  end
            OP_MOV_A_IMM: begin o_dest = DST_A;   o_src = SRC_IMM; end
            OP_MOV_B_A:   begin o_dest = DST_B;   o_src = SRC_A;   end
            OP_ADD_B:     begin o_dest = DST_B;   o_src = SRC_SUM; o_is_add = 1'b1; end
            OP_IN_B:      begin o_dest = DST_B;   o_src = SRC_SW;  end
            OP_MOV_B_IMM: begin o_dest = DST_B;   o_src = SRC_IMM; end
            OP_OUT_B:     begin o_dest = DST_OUT; o_src = SRC_B;   end
            OP_OUT_IMM:   begin o_dest = DST_OUT; o_src = SRC_IMM; end
            // JNC looks at the carry left by the previous instruction
            OP_JNC:       o_jump_taken = ~i_cf;
            OP_JMP:       o_jump_taken = 1'b1;
            default:      ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/td4_core_param.sv
`default_nettype none
// ============================================================================
// Module   : td4_core_param
// Brief    : Two-register TD4-style CPU with configurable data/address widths,
//            handshaked instruction fetch and carry-driven control flow.
// Revision : 1.0 - initial release
// ============================================================================
module td4_core_param
    import td4_pkg::*;
#(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_valid,
    input  logic [OPW+DW-1:0] imem_data,
    input  logic [DW-1:0]     switch_in,
    output logic [DW-1:0]     out_port,
    output logic              out_strobe,
    output logic              retire,
    output logic              cf_out
);

    state_t            r_state;
    state_t            w_state_next;
    logic [DW-1:0]     r_a;
    logic [DW-1:0]     r_b;
    logic [DW-1:0]     r_out;
    logic              r_cf;
    logic              r_strobe;
    logic [AW-1:0]     r_pc;
    logic [OPW+DW-1:0] r_ir;

    logic [DW-1:0]     w_imm;
    logic [DW-1:0]     w_add_op;
    logic [DW:0]       w_sum;
    logic [DW-1:0]     w_src;
    logic [AW-1:0]     w_target;
    dest_t             w_dest;
    src_t              w_src_sel;
    logic              w_is_add;
    logic              w_jump;
    logic              w_exec;
    logic              w_fetch_hit;

    assign w_imm       = r_ir[DW-1:0];
    assign w_exec      = (r_state == EXEC);
    assign w_fetch_hit = (r_state == FETCH) && run && imem_valid;

    td4_decode u_decode (
        .i_opcode     (r_ir[OPW+DW-1:DW]),
        .i_cf         (r_cf),
        .o_dest       (w_dest),
        .o_src        (w_src_sel),
        .o_is_add     (w_is_add),
        .o_jump_taken (w_jump)
    );

    // One adder serves both ADD A and ADD B; the destination picks the operand
    assign w_add_op = (w_dest == DST_B) ? r_b : r_a;
    assign w_sum    = {1'b0, w_add_op} + {1'b0, w_imm};

    always_comb begin
        case (w_src_sel)
            SRC_A:   w_src = r_a;
            SRC_B:   w_src = r_b;
            SRC_SW:  w_src = switch_in;
            SRC_SUM: w_src = w_sum[DW-1:0];
            default: w_src = w_imm;
        endcase
    end

    generate
        if (AW <= DW) begin : g_tgt_trunc
            assign w_target = w_imm[AW-1:0];
        end else begin : g_tgt_ext
            assign w_target = {{(AW-DW){1'b0}}, w_imm};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH:   if (run && imem_valid) w_state_next = EXEC;
            EXEC:    w_state_next = FETCH;
            default: w_state_next = FETCH;
        endcase
    end

    // Outputs are forced low while reset is held, not just after it
    always_comb begin
        imem_req = 1'b0;
        retire   = 1'b0;
        if (!rst) begin
            case (r_state)
                FETCH:   imem_req = run;
                EXEC:    retire   = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_out    <= '0;
            r_cf     <= 1'b0;
            r_strobe <= 1'b0;
            r_pc     <= '0;
            r_ir     <= '0;
        end else begin
            r_strobe <= 1'b0;
            if (w_fetch_hit) begin
                r_ir <= imem_data;
            end
            if (w_exec) begin
                case (w_dest)
                    DST_A:   r_a <= w_src;
                    DST_B:   r_b <= w_src;
                    DST_OUT: begin
                        r_out    <= w_src;
                        r_strobe <= 1'b1;
                    end
                    default: ;
                endcase
                r_cf <= w_is_add & w_sum[DW];
                r_pc <= w_jump ? w_target : r_pc + AW'(1);
            end
        end
    end

    assign imem_addr  = r_pc;
    assign out_port   = r_out;
    assign out_strobe = r_strobe;
    assign cf_out     = r_cf;

endmodule
`default_nettype wire

// File: tb/tb_td4_core_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_td4_core_param
// Brief    : Directed, table-driven bench for td4_core_param (DW=4/AW=4 and
//            DW=8/AW=6 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_td4_core_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       imem_valid;
    logic [7:0] imem_data;
    logic [3:0] switch_in;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic [3:0] out_port;
    logic       out_strobe;
    logic       retire;
    logic       cf_out;

    logic        run2;
    logic        valid2;
    logic [11:0] data2;
    logic [7:0]  sw2;
    logic        req2;
    logic [5:0]  addr2;
    logic [7:0]  out2;
    logic        strobe2;
    logic        retire2;
    logic        cf2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    td4_core_param #(.DW(4), .AW(4)) u_dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .switch_in(switch_in), .out_port(out_port),
        .out_strobe(out_strobe), .retire(retire), .cf_out(cf_out)
    );

    td4_core_param #(.DW(8), .AW(6)) u_dut2 (
        .clk(clk), .rst(rst), .run(run2),
        .imem_req(req2), .imem_addr(addr2),
        .imem_valid(valid2), .imem_data(data2),
        .switch_in(sw2), .out_port(out2),
        .out_strobe(strobe2), .retire(retire2), .cf_out(cf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge in FETCH; returns at the negedge after the EXEC.
    // Garbage is shown on imem_data/switch_in outside the cycles that count.
    task automatic exec(input logic [3:0] op, input logic [3:0] imm,
                        input logic [3:0] sw, input int waits);
        logic [3:0] addr0;
        addr0     = imem_addr;
        switch_in = ~sw;
        check("fetch_req", imem_req, 1);
        for (int w = 0; w < waits; w++) begin
            imem_valid = 1'b0;
            imem_data  = {4'hB, ~imm};
            @(posedge clk); @(negedge clk);
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, addr0);
            check("wait_retire", retire, 0);
        end
        imem_valid = 1'b1;
        imem_data  = {op, imm};
        @(posedge clk); @(negedge clk);
        check("exec_retire", retire, 1);
        check("exec_req", imem_req, 0);
        check("exec_strobe", out_strobe, 0);
        imem_valid = 1'b1;
        imem_data  = 8'hF0;
        switch_in  = sw;
        @(posedge clk); @(negedge clk);
        imem_valid = 1'b0;
        check("post_retire", retire, 0);
    endtask

    task automatic exec2(input logic [3:0] op, input logic [7:0] imm);
        valid2 = 1'b1;
        data2  = {op, imm};
        @(posedge clk); @(negedge clk);
        valid2 = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [3:0] imm;
        logic [3:0] sw;
        logic [3:0] pc;
        logic [3:0] out;
        logic       cf;
        logic       stb;
    } vec_t;

    vec_t vecs[22];

    initial begin
        //          op    imm   sw    pc    out   cf    stb
        vecs[0]  = '{4'h3, 4'h9, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0}; // MOV A,9
        vecs[1]  = '{4'h0, 4'h8, 4'h0, 4'h2, 4'h0, 1'b1, 1'b0}; // ADD A,8 -> 1,c
        vecs[2]  = '{4'h8, 4'h0, 4'h0, 4'h3, 4'h0, 1'b0, 1'b0}; // NOP clears cf
        vecs[3]  = '{4'h4, 4'h0, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0}; // MOV B,A
        vecs[4]  = '{4'h9, 4'h0, 4'h0, 4'h5, 4'h1, 1'b0, 1'b1}; // OUT B
        vecs[5]  = '{4'h3, 4'hF, 4'h0, 4'h6, 4'h1, 1'b0, 1'b0}; // MOV A,15
        vecs[6]  = '{4'h0, 4'h1, 4'h0, 4'h7, 4'h1, 1'b1, 1'b0}; // ADD A,1 -> 0,c
        vecs[7]  = '{4'hE, 4'h2, 4'h0, 4'h8, 4'h1, 1'b0, 1'b0}; // JNC not taken
        vecs[8]  = '{4'hE, 4'hC, 4'h0, 4'hC, 4'h1, 1'b0, 1'b0}; // JNC taken
        vecs[9]  = '{4'h6, 4'h0, 4'hA, 4'hD, 4'h1, 1'b0, 1'b0}; // IN B
        vecs[10] = '{4'h9, 4'h0, 4'h0, 4'hE, 4'hA, 1'b0, 1'b1}; // OUT B
        vecs[11] = '{4'hB, 4'h6, 4'h0, 4'hF, 4'h6, 1'b0, 1'b1}; // OUT 6
        vecs[12] = '{4'hF, 4'h3, 4'h0, 4'h3, 4'h6, 1'b0, 1'b0}; // JMP 3
        vecs[13] = '{4'h5, 4'h7, 4'h0, 4'h4, 4'h6, 1'b1, 1'b0}; // ADD B,7 -> 1,c
        vecs[14] = '{4'h9, 4'h0, 4'h0, 4'h5, 4'h1, 1'b0, 1'b1}; // OUT B
        vecs[15] = '{4'h2, 4'h0, 4'h5, 4'h6, 4'h1, 1'b0, 1'b0}; // IN A
        vecs[16] = '{4'h4, 4'h0, 4'h0, 4'h7, 4'h1, 1'b0, 1'b0}; // MOV B,A
        vecs[17] = '{4'h9, 4'h0, 4'h0, 4'h8, 4'h5, 1'b0, 1'b1}; // OUT B
        vecs[18] = '{4'h7, 4'h2, 4'h0, 4'h9, 4'h5, 1'b0, 1'b0}; // MOV B,2
        vecs[19] = '{4'h1, 4'h0, 4'h0, 4'hA, 4'h5, 1'b0, 1'b0}; // MOV A,B
        vecs[20] = '{4'h0, 4'hF, 4'h0, 4'hB, 4'h5, 1'b1, 1'b0}; // ADD A,15 -> 1,c
        vecs[21] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 1'b0}; // JMP 0 clears cf

        rst = 1'b1; run = 1'b1; imem_valid = 1'b0; imem_data = '0; switch_in = '0;
        run2 = 1'b1; valid2 = 1'b0; data2 = '0; sw2 = '0;
        repeat (2) @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_retire", retire, 0);
        check("rst_strobe", out_strobe, 0);
        check("rst_out", out_port, 0);
        check("rst_cf", cf_out, 0);
        check("rst_addr", imem_addr, 0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rel_req", imem_req, 1);

        for (int i = 0; i < 22; i++) begin
            exec(vecs[i].op, vecs[i].imm, vecs[i].sw, 0);
            check($sformatf("v%0d_pc", i), imem_addr, vecs[i].pc);
            check($sformatf("v%0d_cf", i), cf_out, vecs[i].cf);
            check($sformatf("v%0d_out", i), out_port, vecs[i].out);
            check($sformatf("v%0d_stb", i), out_strobe, vecs[i].stb);
        end

        // Wait states: OUT 3 with bogus OUT C shown while valid is low
        exec(4'hB, 4'h3, 4'h0, 3);
        check("ws_out", out_port, 3);
        check("ws_pc", imem_addr, 1);
        exec(4'hF, 4'h0, 4'h0, 0);
        check("jmp0_pc", imem_addr, 0);

        for (int i = 0; i < 16; i++) begin
            check("wrap_addr_pre", imem_addr, i);
            exec(4'h8, 4'h0, 4'h0, 0);
        end
        check("wrap_addr", imem_addr, 0);

        // run=0 holds FETCH even with a valid instruction on the bus
        run = 1'b0; imem_valid = 1'b1; imem_data = {4'hB, 4'h7};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("hold_req", imem_req, 0);
            check("hold_addr", imem_addr, 0);
            check("hold_retire", retire, 0);
        end
        imem_valid = 1'b0; run = 1'b1;
        @(posedge clk); @(negedge clk);
        check("hold_out", out_port, 3);
        check("resume_req", imem_req, 1);

        // Reset in the EXEC of ADD A,5 with A=3
        exec(4'h3, 4'h3, 4'h0, 0);
        exec(4'hB, 4'h9, 4'h0, 0);
        check("pre_rst_out", out_port, 9);
        imem_valid = 1'b1; imem_data = {4'h0, 4'h5};
        @(posedge clk); @(negedge clk);
        check("mid_retire", retire, 1);
        rst = 1'b1; imem_valid = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_retire", retire, 0);
        check("mid_rst_addr", imem_addr, 0);
        check("mid_rst_out", out_port, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("post_rst_req", imem_req, 1);
        check("post_rst_addr", imem_addr, 0);
        check("post_rst_cf", cf_out, 0);
        exec(4'h0, 4'h1, 4'h0, 0);
        check("post_rst_add_cf", cf_out, 0);
        exec(4'h4, 4'h0, 4'h0, 0);
        exec(4'h9, 4'h0, 4'h0, 0);
        check("post_rst_a", out_port, 1);

        // Wider instance: target truncation, 8-bit data and carry
        exec2(4'hF, 8'hC5);
        check("w_jmp_addr", addr2, 6'h05);
        exec2(4'hB, 8'hA7);
        check("w_out", out2, 8'hA7);
        check("w_stb", strobe2, 1);
        check("w_addr", addr2, 6'h06);
        exec2(4'h0, 8'hFF);
        check("w_add_cf0", cf2, 0);
        exec2(4'h0, 8'h01);
        check("w_add_cf1", cf2, 1);
        exec2(4'h4, 8'h00);
        exec2(4'h9, 8'h00);
        check("w_sum_out", out2, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
